// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA timing generator:
//   - axis_state_t : 2-bit region encoding used by both the H and V axis FSMs
//   - VGA_*        : default 640x480 @ 60 Hz region lengths
//   - sync_level() : maps an axis region plus polarity to a sync pin level
// No ports (package).
// ---------------------------------------------------------------------------
package vga_pkg;

    typedef enum logic [1:0] {
        ST_DISPLAY = 2'd0,
        ST_FRONT   = 2'd1,
        ST_SYNC    = 2'd2,
        ST_BACK    = 2'd3
    } axis_state_t;

    localparam int VGA_H_DISPLAY = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_V_DISPLAY = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;

    // A sync pin sits at its active level only while its axis is in SYNC.
    function automatic logic sync_level(input axis_state_t st, input logic pol);
        return (st == ST_SYNC) ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_axis_fsm.sv
// ---------------------------------------------------------------------------
// vga_axis_fsm
// One timing axis (horizontal or vertical): a position counter that wraps at
// the sum of the four region lengths, a DISPLAY/FRONT/SYNC/BACK region FSM,
// and a scaled address that steps once every SCALE enabled steps while in
// DISPLAY and is held at zero elsewhere.
// Ports:
//   i_clk   : clock
//   i_rst_n : synchronous active-low reset
//   i_en    : advance enable (pixel tick for H, line end for V)
//   o_state : current region (registered)
//   o_addr  : scaled address within the display region (registered)
//   o_last  : high while the counter holds its final position
// ---------------------------------------------------------------------------
module vga_axis_fsm
    import vga_pkg::*;
#(
    parameter int DISPLAY = 640,
    parameter int FRONT   = 16,
    parameter int SYNC    = 96,
    parameter int BACK    = 48,
    parameter int SCALE   = 5,
    parameter int ADDR_W  = 7
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    output axis_state_t       o_state,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last
);

    localparam int TOTAL = DISPLAY + FRONT + SYNC + BACK;
    localparam int CNT_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int SUB_W = (SCALE > 1) ? $clog2(SCALE) : 1;

    // Final count of each region; the FSM leaves a region on the step out of it.
    localparam logic [CNT_W-1:0] END_DISP  = CNT_W'(DISPLAY - 1);
    localparam logic [CNT_W-1:0] END_FRONT = CNT_W'(DISPLAY + FRONT - 1);
    localparam logic [CNT_W-1:0] END_SYNC  = CNT_W'(DISPLAY + FRONT + SYNC - 1);
    localparam logic [CNT_W-1:0] END_TOTAL = CNT_W'(TOTAL - 1);
    localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(SCALE - 1);

    logic [CNT_W-1:0]  r_count;
    axis_state_t       r_state;
    logic [SUB_W-1:0]  r_sub;
    logic [ADDR_W-1:0] r_addr;
    logic              w_last;

    assign w_last  = (r_count == END_TOTAL);
    assign o_last  = w_last;
    assign o_state = r_state;
    assign o_addr  = r_addr;

    // Counter, region FSM and scaled address all move together on an enabled
    // step. The address is zeroed on the step that leaves DISPLAY so it is
    // already 0 for the first non-display position.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
            r_state <= ST_DISPLAY;
            r_sub   <= '0;
            r_addr  <= '0;
        end else if (i_en) begin
            r_count <= w_last ? '0 : r_count + 1'b1;

            case (r_state)
                ST_DISPLAY: if (r_count == END_DISP)  r_state <= ST_FRONT;
                ST_FRONT:   if (r_count == END_FRONT) r_state <= ST_SYNC;
                ST_SYNC:    if (r_count == END_SYNC)  r_state <= ST_BACK;
                ST_BACK:    if (w_last)               r_state <= ST_DISPLAY;
                default:                              r_state <= ST_DISPLAY;
            endcase

            if ((r_state == ST_DISPLAY) && (r_count != END_DISP)) begin
                if (r_sub == SUB_LAST) begin
                    r_sub  <= '0;
                    r_addr <= r_addr + 1'b1;
                end else begin
                    r_sub  <= r_sub + 1'b1;
                end
            end else begin
                r_sub  <= '0;
                r_addr <= '0;
            end
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// VGA raster timing: horizontal and vertical axis FSMs with scaled pixel
// addresses, sync decode and line/frame pulses.
// Ports:
//   clk          : system clock
//   reset        : synchronous active-low reset
//   pixel_clk    : pixel-tick enable sampled on clk rising edge
//   hsync/vsync  : sync outputs, active level set by SYNC_POL
//   display_time : high when both axes are in their display region
//   hpixel/vpixel: scaled column/row address, 0 outside display
//   line_end     : one-clk pulse on the last pixel tick of a line
//   frame_start  : one-clk pulse on the tick that wraps to h=0,v=0
// ---------------------------------------------------------------------------
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_DISPLAY = VGA_H_DISPLAY,
    parameter int H_FRONT   = VGA_H_FRONT,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BACK    = VGA_H_BACK,
    parameter int V_DISPLAY = VGA_V_DISPLAY,
    parameter int V_FRONT   = VGA_V_FRONT,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BACK    = VGA_V_BACK,
    parameter int H_SCALE   = 5,
    parameter int V_SCALE   = 5,
    parameter int ADDR_W    = 7,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pixel_clk,
    output logic              hsync,
    output logic              vsync,
    output logic              display_time,
    output logic [ADDR_W-1:0] hpixel,
    output logic [ADDR_W-1:0] vpixel,
    output logic              line_end,
    output logic              frame_start
);

    axis_state_t w_h_state;
    axis_state_t w_v_state;
    logic        w_h_last;
    logic        w_v_last;
    logic        w_line_end;

    // Gated by reset so no pulse escapes while the counters are being cleared.
    assign w_line_end = reset & pixel_clk & w_h_last;

    vga_axis_fsm #(
        .DISPLAY (H_DISPLAY),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK),
        .SCALE   (H_SCALE),
        .ADDR_W  (ADDR_W)
    ) u_h_axis (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_en    (pixel_clk),
        .o_state (w_h_state),
        .o_addr  (hpixel),
        .o_last  (w_h_last)
    );

    // The vertical axis steps once per line, on the line's final pixel tick.
    vga_axis_fsm #(
        .DISPLAY (V_DISPLAY),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK),
        .SCALE   (V_SCALE),
        .ADDR_W  (ADDR_W)
    ) u_v_axis (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_en    (w_line_end),
        .o_state (w_v_state),
        .o_addr  (vpixel),
        .o_last  (w_v_last)
    );

    assign hsync        = sync_level(w_h_state, SYNC_POL);
    assign vsync        = sync_level(w_v_state, SYNC_POL);
    assign display_time = (w_h_state == ST_DISPLAY) && (w_v_state == ST_DISPLAY);
    assign line_end     = w_line_end;
    assign frame_start  = w_line_end & w_v_last;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
// Three generators share clk/reset/pixel_clk: a reduced-size frame with
// active-low sync, the same frame with active-high sync and another scale,
// and one at the full 640x480 defaults. A tick-count model derives every
// expected output from (tick index mod line/frame length).
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    typedef struct packed {
        int hd; int hf; int hs; int hb;
        int vd; int vf; int vs; int vb;
        int hsc; int vsc; int aw;
        bit pol;
    } timing_t;

    typedef struct packed {
        logic hsync; logic vsync; logic disp;
        int hpix; int vpix; int h; int v;
        int ht; int vt;
    } expect_t;

    logic clk = 1'b0;
    logic reset;
    logic pixel_clk;

    logic hsA, vsA, dA, leA, fsA;
    logic [3:0] hpA, vpA;
    logic hsB, vsB, dB, leB, fsB;
    logic [2:0] hpB, vpB;
    logic hsD, vsD, dD, leD, fsD;
    logic [6:0] hpD, vpD;

    timing_t pA, pB, pD;

    int t = 0;
    int absTick = 0;
    int compCount = 0;
    int failCount = 0;

    int syncStartD = -1, syncLowD = 0;
    int lastLineEndD = -1, lineGapD = -1;
    int lastFrameA = -1, frameGapA = -1;
    int lastFrameB = -1, frameGapB = -1;
    int vsyncStartLineB = -1, vsyncHighTicksB = 0;
    int hsyncStartB = -1, hsyncHighTicksB = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_DISPLAY(40), .H_FRONT(4), .H_SYNC(6), .H_BACK(5),
        .V_DISPLAY(30), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
        .H_SCALE(4), .V_SCALE(3), .ADDR_W(4), .SYNC_POL(1'b0)
    ) dutA (
        .clk(clk), .reset(reset), .pixel_clk(pixel_clk),
        .hsync(hsA), .vsync(vsA), .display_time(dA),
        .hpixel(hpA), .vpixel(vpA), .line_end(leA), .frame_start(fsA)
    );

    vga_timing_gen #(
        .H_DISPLAY(40), .H_FRONT(4), .H_SYNC(6), .H_BACK(5),
        .V_DISPLAY(30), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
        .H_SCALE(5), .V_SCALE(5), .ADDR_W(3), .SYNC_POL(1'b1)
    ) dutB (
        .clk(clk), .reset(reset), .pixel_clk(pixel_clk),
        .hsync(hsB), .vsync(vsB), .display_time(dB),
        .hpixel(hpB), .vpixel(vpB), .line_end(leB), .frame_start(fsB)
    );

    vga_timing_gen dutD (
        .clk(clk), .reset(reset), .pixel_clk(pixel_clk),
        .hsync(hsD), .vsync(vsD), .display_time(dD),
        .hpixel(hpD), .vpixel(vpD), .line_end(leD), .frame_start(fsD)
    );

    // Raster position and outputs follow directly from the tick index.
    function automatic expect_t model(input timing_t p, input int tt);
        expect_t e;
        e.ht    = p.hd + p.hf + p.hs + p.hb;
        e.vt    = p.vd + p.vf + p.vs + p.vb;
        e.h     = tt % e.ht;
        e.v     = (tt / e.ht) % e.vt;
        e.hsync = ((e.h >= p.hd + p.hf) && (e.h < p.hd + p.hf + p.hs)) ? p.pol : ~p.pol;
        e.vsync = ((e.v >= p.vd + p.vf) && (e.v < p.vd + p.vf + p.vs)) ? p.pol : ~p.pol;
        e.disp  = (e.h < p.hd) && (e.v < p.vd);
        e.hpix  = (e.h < p.hd) ? (e.h / p.hsc) % (1 << p.aw) : 0;
        e.vpix  = (e.v < p.vd) ? (e.v / p.vsc) % (1 << p.aw) : 0;
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
        end
    endtask

    task automatic checkState(input string name, input timing_t p,
                              input logic hsO, input logic vsO, input logic dO,
                              input logic [31:0] hpO, input logic [31:0] vpO);
        expect_t e;
        e = model(p, t);
        checkOutput({name, " hsync"},        32'(hsO), 32'(e.hsync));
        checkOutput({name, " vsync"},        32'(vsO), 32'(e.vsync));
        checkOutput({name, " display_time"}, 32'(dO),  32'(e.disp));
        checkOutput({name, " hpixel"},       hpO,      32'(e.hpix));
        checkOutput({name, " vpixel"},       vpO,      32'(e.vpix));
    endtask

    task automatic checkPulses(input string name, input timing_t p,
                               input logic leO, input logic fsO,
                               input logic pc, input logic rstn);
        expect_t e;
        logic expLe;
        e = model(p, t);
        expLe = rstn && pc && (e.h == e.ht - 1);
        checkOutput({name, " line_end"},    32'(leO), 32'(expLe));
        checkOutput({name, " frame_start"}, 32'(fsO), 32'(expLe && (e.v == e.vt - 1)));
    endtask

    // One clk: drive inputs at the falling edge, check the tick-qualified
    // pulses, then advance the model and check the registered outputs.
    task automatic applyStimulus(input logic pc, input logic rstn);
        @(negedge clk);
        pixel_clk = pc;
        reset     = rstn;
        #1;
        checkPulses("A", pA, leA, fsA, pc, rstn);
        checkPulses("B", pB, leB, fsB, pc, rstn);
        checkPulses("D", pD, leD, fsD, pc, rstn);
        if (leD === 1'b1) begin
            if (lastLineEndD >= 0) lineGapD = absTick - lastLineEndD;
            lastLineEndD = absTick;
        end
        if (fsA === 1'b1) begin
            if (lastFrameA >= 0) frameGapA = absTick - lastFrameA;
            lastFrameA = absTick;
        end
        if (fsB === 1'b1) begin
            if (lastFrameB >= 0) frameGapB = absTick - lastFrameB;
            lastFrameB = absTick;
        end

        @(posedge clk);
        #1;
        if (!rstn) begin
            t = 0;
        end else if (pc) begin
            t++;
            absTick++;
            if (t < 800 && hsD === 1'b0) begin
                if (syncLowD == 0) syncStartD = t;
                syncLowD++;
            end
            if (t < 55 && hsB === 1'b1) begin
                if (hsyncHighTicksB == 0) hsyncStartB = t;
                hsyncHighTicksB++;
            end
            if (t < 2035 && vsB === 1'b1) begin
                if (vsyncHighTicksB == 0) vsyncStartLineB = t / 55;
                vsyncHighTicksB++;
            end
        end
        checkState("A", pA, hsA, vsA, dA, 32'(hpA), 32'(vpA));
        checkState("B", pB, hsB, vsB, dB, 32'(hpB), 32'(vpB));
        checkState("D", pD, hsD, vsD, dD, 32'(hpD), 32'(vpD));
    endtask

    initial begin
        pA = '{hd: 40, hf: 4, hs: 6, hb: 5, vd: 30, vf: 2, vs: 2, vb: 3,
               hsc: 4, vsc: 3, aw: 4, pol: 1'b0};
        pB = '{hd: 40, hf: 4, hs: 6, hb: 5, vd: 30, vf: 2, vs: 2, vb: 3,
               hsc: 5, vsc: 5, aw: 3, pol: 1'b1};
        pD = '{hd: 640, hf: 16, hs: 96, hb: 48, vd: 480, vf: 10, vs: 2, vb: 33,
               hsc: 5, vsc: 5, aw: 7, pol: 1'b0};
        reset     = 1'b0;
        pixel_clk = 1'b0;
        $display("[TB] tb_vga_timing_gen starting");

        // Reset held with and without pixel ticks.
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);

        // Two full default-size lines with a tick on every 4th clk.
        for (int i = 0; i < 1620 * 4; i++) applyStimulus(((i % 4) == 3), 1'b1);
        checkOutput("D hsync first low h",  32'(syncStartD), 32'd656);
        checkOutput("D hsync low ticks",    32'(syncLowD),   32'd96);
        checkOutput("D line period ticks",  32'(lineGapD),   32'd800);
        checkOutput("B hsync first high h", 32'(hsyncStartB), 32'd44);
        checkOutput("B hsync high ticks",   32'(hsyncHighTicksB), 32'd6);

        // Freeze mid-display for 50 clks.
        for (int i = 0; i < 50; i++) applyStimulus(1'b0, 1'b1);

        // Random pixel ticks across two reduced-frame boundaries.
        for (int i = 0; i < 20000 && absTick < 4200; i++)
            applyStimulus(1'($urandom_range(0, 1)), 1'b1);
        checkOutput("A frame period ticks", 32'(frameGapA), 32'd2035);
        checkOutput("B frame period ticks", 32'(frameGapB), 32'd2035);
        checkOutput("B vsync first line",   32'(vsyncStartLineB), 32'd32);
        checkOutput("B vsync high ticks",   32'(vsyncHighTicksB), 32'd110);

        // Abandon a frame part-way through, then restart from h=0,v=0.
        for (int i = 0; i < int'($urandom_range(100, 1500)); i++)
            applyStimulus(1'($urandom_range(0, 1)), 1'b1);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 300; i++)
            applyStimulus(1'($urandom_range(0, 1)), 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL provide parameters (name, default, meaning), one per line:
  H_DISPLAY, 640, active pixels per line
  H_FRONT, 16, horizontal front-porch pixels
  H_SYNC, 96, horizontal sync-pulse pixels
  H_BACK, 48, horizontal back-porch pixels
  V_DISPLAY, 480, active lines per frame
  V_FRONT, 10, vertical front-porch lines
  V_SYNC, 2, vertical sync-pulse lines
  V_BACK, 33, vertical back-porch lines
  H_SCALE, 5, pixel ticks per horizontal address step
  V_SCALE, 5, lines per vertical address step
  ADDR_W, 7, width of hpixel/vpixel
  SYNC_POL, 0, sync active level (0 = active-low)
REQ-002 SHALL provide ports (name, direction, width, meaning), one per line:
  clk, in, 1, system clock
  reset, in, 1, synchronous active-low reset
  pixel_clk, in, 1, pixel-tick enable, sampled on clk rising edge
  hsync, out, 1, horizontal sync
  vsync, out, 1, vertical sync
  display_time, out, 1, high when both H and V are in display
  hpixel, out, ADDR_W, scaled column address
  vpixel, out, ADDR_W, scaled row address
  line_end, out, 1, one-clk pulse on last pixel tick of a line
  frame_start, out, 1, one-clk pulse on the tick entering h=0,v=0

Function
REQ-003 SHALL keep h_count in 0..H_TOTAL-1 (H_TOTAL = sum of H_* timings), advancing only on clk edges with pixel_clk=1, and wrapping to 0 after H_TOTAL-1.
REQ-004 SHALL advance v_count only on a tick where h_count=H_TOTAL-1, wrapping to 0 after V_TOTAL-1.
REQ-005 SHALL implement a 4-state H FSM: DISPLAY -> FRONT -> SYNC -> BACK -> DISPLAY, with each transition taken on the tick leaving the last count of its region; h_count=0 is the first DISPLAY pixel.
REQ-006 SHALL implement an identical 4-state V FSM driven by line ticks.
REQ-007 SHALL decode all sync outputs as Moore outputs from the registered state: hsync=SYNC_POL in H SYNC and ~SYNC_POL otherwise; vsync the same in V SYNC.
REQ-008 SHALL assert display_time only when H=DISPLAY and V=DISPLAY.
REQ-009 SHALL step hpixel by 1 after every H_SCALE display ticks (sub-counter 0..H_SCALE-1) and force hpixel and its sub-counter to 0 whenever H is not DISPLAY.
REQ-010 SHALL step vpixel by 1 after every V_SCALE display lines on line_end, hold it between lines, and force it to 0 whenever V is not DISPLAY.
REQ-011 SHALL make hpixel/vpixel wrap modulo 2^ADDR_W without flagging; ADDR_W >= clog2(H_DISPLAY/H_SCALE) is a parameter precondition.
REQ-012 SHALL make pixel_clk=0 freeze all counters, states and addresses, and SHALL hold line_end and frame_start low.
REQ-013 SHALL combine line_end with the last line of the frame in the same clk as frame_start when both apply.

Reset
REQ-014 SHALL, on reset=0 at a clk edge, set h_count=0, v_count=0 and both FSMs to DISPLAY, and clear hpixel, vpixel and all sub-counters.
REQ-015 SHALL hold display_time=1, syncs inactive, and line_end and frame_start at 0 while reset is active.
REQ-016 SHALL, on reset asserted mid-line or mid-frame, abandon the line or frame, with the first pixel_clk tick after release counting as h_count=0.

Structure
REQ-017 SHALL place the state encoding (2-bit: DISPLAY, FRONT, SYNC, BACK) and the default 640x480 timing constants in shared package vga_pkg.
REQ-018 SHALL instantiate sub-module vga_axis_fsm (counter + 4-state FSM + scale sub-counter, parametrised by region lengths and scale) twice, once for H and once for V, with the V instance enabled by line_end.

Verification
REQ-019 SHALL cover: defaults with pixel_clk every 4th clk -> hsync low for exactly 96 ticks starting at h_count 656, H_TOTAL=800 ticks per line, V_TOTAL=525 lines per frame.
REQ-020 SHALL cover: H_SCALE=5 -> hpixel steps 0..127 each after 5 display ticks and returns to 0 at h_count 640.
REQ-021 SHALL cover: SYNC_POL=1 -> hsync high for 96 ticks and vsync high for 2 lines, with vsync starting at v_count 490.
REQ-022 SHALL cover: reset pulse at h_count 300, v_count 200 -> all outputs at their reset values, and the next tick yields h_count=0 with display_time=1.
REQ-023 SHALL cover: pixel_clk held low for 50 clks mid-display -> no change in any output.
REQ-024 SHALL cover: the last tick of the frame -> line_end=1 and frame_start=1 in the same clk, followed by vpixel=0 and hpixel=0.
